// File: rtl/mod_addsub_vec_if.sv
`default_nettype none
// ============================================================================
// Module      : mod_addsub_vec_if
// Description : Operand/result bundle for the vector modular add/sub unit.
//               master = operand source (drives operands, receives results)
//               slave  = mod_addsub_vec (receives operands, drives results)
//   in_valid  : operands valid this cycle
//   kd_mode   : 0 = Kyber 12-bit lanes, 1 = Dilithium 24-bit words
//   op_vec    : per-lane op, 0 = add, 1 = sub (even bits only in Dilithium)
//   sel_a     : 1 = operand A from the alignment delay line, 0 = live a
//   a, b      : packed operands, lane i at [12i+11:12i]
//   out_valid : result valid
//   sum       : packed result, same packing as a
//   range_err : some operand used by this result was >= its modulus
// Revision    : 1.0 - initial release
// ============================================================================
interface mod_addsub_vec_if #(
  parameter int LANES = 2
);
  logic                  in_valid;
  logic                  kd_mode;
  logic [LANES-1:0]      op_vec;
  logic                  sel_a;
  logic [12*LANES-1:0]   a;
  logic [12*LANES-1:0]   b;
  logic                  out_valid;
  logic [12*LANES-1:0]   sum;
  logic                  range_err;

  modport master (
    output in_valid, kd_mode, op_vec, sel_a, a, b,
    input  out_valid, sum, range_err
  );

  modport slave (
    input  in_valid, kd_mode, op_vec, sel_a, a, b,
    output out_valid, sum, range_err
  );
endinterface
`default_nettype wire

// File: rtl/mod_addsub_vec.sv
`default_nettype none
// ============================================================================
// Module      : mod_addsub_vec
// Description : Pipelined vector modular add/sub for the Kyber/Dilithium
//               NTT datapath. LANES 12-bit lanes mod KQ, or LANES/2 24-bit
//               words mod DQ built by chaining lane pairs. Single-step
//               correction, valid-tagged output pipeline of PIPE stages and
//               a DLY_A-deep alignment delay line for operand A.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : mod_addsub_vec_if.slave (operands in, results out)
// Revision    : 1.0 - initial release
// ============================================================================
module mod_addsub_vec #(
  parameter int LANES = 2,
  parameter int KQ    = 3329,
  parameter int DQ    = 8380417,
  parameter int DLY_A = 6,
  parameter int PIPE  = 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mod_addsub_vec_if.slave    bus
);

  localparam int          W     = 12 * LANES;
  localparam int          WORDS = LANES / 2;
  localparam logic [11:0] KQ12  = 12'(KQ);
  localparam logic [23:0] DQ24  = 24'(DQ);
  localparam logic [11:0] DQ_LO = DQ24[11:0];
  localparam logic [11:0] DQ_HI = DQ24[23:12];

  // --------------------------------------------------------------------------
  // Operand-A alignment delay line: shifts every cycle, independent of
  // in_valid, so the tap is always exactly DLY_A cycles old.
  // --------------------------------------------------------------------------
  logic [W-1:0] r_dly [DLY_A];
  logic [W-1:0] w_a_eff;

  for (genvar k = 0; k < DLY_A; k++) begin : g_dly
    if (k == 0) begin : g_head
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_dly[k] <= '0;
        else      r_dly[k] <= bus.a;
      end
    end else begin : g_tail
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_dly[k] <= '0;
        else      r_dly[k] <= r_dly[k-1];
      end
    end
  end

  assign w_a_eff = bus.sel_a ? r_dly[DLY_A-1] : bus.a;

  // --------------------------------------------------------------------------
  // Per-lane datapath. Each lane has a raw adder (a +/- b) and a correction
  // adder (raw -/+ modulus). In Dilithium mode the odd lane of each pair
  // takes both carries from the even lane, forming 24-bit adders. Subtraction
  // is a + ~b + 1, so a carry out of the top lane means "no borrow".
  // --------------------------------------------------------------------------
  logic [LANES-1:0] w_sub;
  logic [LANES-1:0] w_need;
  logic [LANES-1:0] w_kerr;
  logic [WORDS-1:0] w_derr;
  logic [W-1:0]     w_res;
  logic             w_err;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int HI = i | 1;
    localparam int LO = i - (i % 2);

    logic [11:0] w_ai, w_bi, w_m, w_r, w_t;
    logic        w_cin1, w_cin2, w_c1, w_c2;

    assign w_ai     = w_a_eff[12*i +: 12];
    assign w_bi     = bus.b[12*i +: 12];
    assign w_sub[i] = bus.kd_mode ? bus.op_vec[LO] : bus.op_vec[i];

    if (i % 2 == 1) begin : g_odd
      assign w_cin1 = bus.kd_mode ? g_lane[i-1].w_c1 : w_sub[i];
      assign w_cin2 = bus.kd_mode ? g_lane[i-1].w_c2 : ~w_sub[i];
      assign w_m    = bus.kd_mode ? DQ_HI : KQ12;
    end else begin : g_even
      assign w_cin1 = w_sub[i];
      assign w_cin2 = ~w_sub[i];
      assign w_m    = bus.kd_mode ? DQ_LO : KQ12;
    end

    assign {w_c1, w_r} = {1'b0, w_ai} + {1'b0, w_bi ^ {12{w_sub[i]}}}
                       + {12'b0, w_cin1};
    // add: subtract the modulus (r + ~m + 1); sub: add it back (r + m)
    assign {w_c2, w_t} = {1'b0, w_r} + {1'b0, w_m ^ {12{~w_sub[i]}}}
                       + {12'b0, w_cin2};

    // add: s >= m when the raw sum overflowed or r - m did not borrow
    // sub: the raw difference went negative when no carry came out
    assign w_need[i] = w_sub[i] ? ~w_c1 : (w_c1 | w_c2);

    // in Dilithium mode the odd (top) lane decides for the whole word
    assign w_res[12*i +: 12] = (bus.kd_mode ? w_need[HI] : w_need[i]) ? w_t : w_r;

    assign w_kerr[i] = (w_ai >= KQ12) || (w_bi >= KQ12);
  end

  for (genvar j = 0; j < WORDS; j++) begin : g_word
    assign w_derr[j] = (w_a_eff[24*j +: 24] >= DQ24) || (bus.b[24*j +: 24] >= DQ24);
  end

  assign w_err = bus.kd_mode ? (|w_derr) : (|w_kerr);

  // --------------------------------------------------------------------------
  // Output pipeline. Data registers load only alongside a valid bit so idle
  // cycles keep the previous (defined) contents; valid always advances.
  // --------------------------------------------------------------------------
  logic         r_vld [PIPE];
  logic [W-1:0] r_sum [PIPE];
  logic         r_err [PIPE];

  for (genvar s = 0; s < PIPE; s++) begin : g_pipe
    if (s == 0) begin : g_first
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_vld[s] <= 1'b0;
          r_sum[s] <= '0;
          r_err[s] <= 1'b0;
        end else begin
          r_vld[s] <= bus.in_valid;
          if (bus.in_valid) begin
            r_sum[s] <= w_res;
            r_err[s] <= w_err;
          end
        end
      end
    end else begin : g_next
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_vld[s] <= 1'b0;
          r_sum[s] <= '0;
          r_err[s] <= 1'b0;
        end else begin
          r_vld[s] <= r_vld[s-1];
          if (r_vld[s-1]) begin
            r_sum[s] <= r_sum[s-1];
            r_err[s] <= r_err[s-1];
          end
        end
      end
    end
  end

  assign bus.out_valid = r_vld[PIPE-1];
  assign bus.sum       = r_sum[PIPE-1];
  assign bus.range_err = r_err[PIPE-1];

endmodule
`default_nettype wire

// File: tb/tb_mod_addsub_vec.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_addsub_vec
// Description : Self-checking bench for mod_addsub_vec (LANES=2, PIPE=3,
//               DLY_A=6). Directed vector table, delay-line sequence,
//               back-to-back mixed-mode ops and a mid-flight reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_addsub_vec;

  localparam int LANES = 2;
  localparam int PIPE  = 3;
  localparam int DLY_A = 6;
  localparam int KQ    = 3329;
  localparam int DQ    = 8380417;
  localparam int NVEC  = 14;

  typedef struct {
    logic        kd;
    logic [1:0]  op;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] exp_sum;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          due;
    logic [23:0] sum;
    logic        err;
    int          tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mod_addsub_vec_if #(.LANES(LANES)) bus ();

  mod_addsub_vec #(
    .LANES (LANES),
    .KQ    (KQ),
    .DQ    (DQ),
    .DLY_A (DLY_A),
    .PIPE  (PIPE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  exp_t q[$];
  vec_t tbl [NVEC];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] kv(input int hi, input int lo);
    return {hi[11:0], lo[11:0]};
  endfunction

  // Plain integer reference: formula result with single correction step.
  function automatic void model(input logic kd, input logic [1:0] op,
                                input logic [23:0] a, input logic [23:0] b,
                                output logic [23:0] s, output logic e);
    s = '0;
    e = 1'b0;
    if (!kd) begin
      for (int i = 0; i < 2; i++) begin
        int x = int'(a[12*i +: 12]);
        int y = int'(b[12*i +: 12]);
        int r;
        if (op[i]) begin r = x - y; if (r < 0)   r = r + KQ; end
        else       begin r = x + y; if (r >= KQ) r = r - KQ; end
        s[12*i +: 12] = r[11:0];
        if (x >= KQ || y >= KQ) e = 1'b1;
      end
    end else begin
      int x = int'(a);
      int y = int'(b);
      int r;
      if (op[0]) begin r = x - y; if (r < 0)   r = r + DQ; end
      else       begin r = x + y; if (r >= DQ) r = r - DQ; end
      s = r[23:0];
      if (x >= DQ || y >= DQ) e = 1'b1;
    end
  endfunction

  // Scoreboard: every out_valid must match the oldest pending entry at the
  // exact cycle it is due.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check("spurious out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          check($sformatf("latency #%0d", e.tag), cyc, e.due);
          check($sformatf("sum #%0d", e.tag), 32'(bus.sum), 32'(e.sum));
          check($sformatf("range_err #%0d", e.tag), 32'(bus.range_err), 32'(e.err));
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        check($sformatf("missing out_valid #%0d", q[0].tag), 32'(bus.out_valid), 32'd1);
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(input logic kd, input logic [1:0] op, input logic sel,
                       input logic [23:0] a, input logic [23:0] b,
                       input logic [23:0] es, input logic ee, input int tag);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.kd_mode  = kd;
    bus.op_vec   = op;
    bus.sel_a    = sel;
    bus.a        = a;
    bus.b        = b;
    q.push_back('{due: cyc + PIPE, sum: es, err: ee, tag: tag});
  endtask

  task automatic drain(input string name);
    int k = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 24'h5A5A5A;
    bus.b        = 24'hA5A5A5;
    while (q.size() > 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (q.size() > 0) begin
      check({name, " drain timeout"}, q.size(), 0);
      q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.kd_mode  = 1'b0;
    bus.op_vec   = '0;
    bus.sel_a    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    rst          = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [23:0] es, ra, rb;
    logic        ee, seen;
    logic [1:0]  rop;
    int          x0, x1;

    tbl[0]  = '{1'b0, 2'b00, kv(10, 3000),  kv(20, 500),  kv(30, 171),    1'b0};
    tbl[1]  = '{1'b0, 2'b11, kv(3328, 5),   kv(0, 10),    kv(3328, 3324), 1'b0};
    tbl[2]  = '{1'b0, 2'b01, kv(3328, 5),   kv(0, 10),    kv(3328, 3324), 1'b0};
    tbl[3]  = '{1'b1, 2'b10, 24'd8380000,   24'd1000,     24'd583,        1'b0};
    tbl[4]  = '{1'b1, 2'b01, 24'd0,         24'd1,        24'd8380416,    1'b0};
    tbl[5]  = '{1'b1, 2'b00, 24'd8380416,   24'd1,        24'd0,          1'b0};
    tbl[6]  = '{1'b0, 2'b00, kv(0, 3329),   kv(0, 0),     kv(0, 0),       1'b1};
    tbl[7]  = '{1'b0, 2'b10, kv(4095, 1),   kv(0, 2),     kv(4095, 3),    1'b1};
    tbl[8]  = '{1'b1, 2'b00, 24'd0,         24'd8380417,  24'd0,          1'b1};
    tbl[9]  = '{1'b1, 2'b00, 24'd4095,      24'd1,        24'd4096,       1'b0};
    tbl[10] = '{1'b0, 2'b00, kv(3328, 3328), kv(3328, 3328), kv(3327, 3327), 1'b0};
    tbl[11] = '{1'b0, 2'b00, kv(1, 3000),   kv(2, 329),   kv(3, 0),       1'b0};
    tbl[12] = '{1'b1, 2'b11, 24'd5000000,   24'd6000000,  24'd7380417,    1'b0};
    tbl[13] = '{1'b0, 2'b10, kv(0, 3328),   kv(1, 1),     kv(3328, 0),    1'b0};

    bus.in_valid = 1'b0;
    bus.kd_mode  = 1'b0;
    bus.op_vec   = '0;
    bus.sel_a    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset sum", 32'(bus.sum), 32'd0);
    check("reset range_err", 32'(bus.range_err), 32'd0);
    rst = 1'b1;

    // directed vectors, issued back to back
    for (int i = 0; i < NVEC; i++)
      issue(tbl[i].kd, tbl[i].op, 1'b0, tbl[i].a, tbl[i].b,
            tbl[i].exp_sum, tbl[i].exp_err, i);
    drain("table");

    // delay line: a = k (lane1 offset by 1000), b = 0, add
    do_reset();
    for (int k = 0; k < 20; k++) begin
      logic sel = (k < DLY_A) || (k >= 10);
      if (!sel)         es = kv(k + 1000, k);
      else if (k < DLY_A) es = 24'd0;
      else              es = kv(k - DLY_A + 1000, k - DLY_A);
      issue(1'b0, 2'b00, sel, kv(k + 1000, k), 24'd0, es, 1'b0, 100 + k);
    end
    drain("delay");

    // 16 back-to-back ops, alternating mode, against the reference model
    for (int i = 0; i < 16; i++) begin
      logic kd = i[0];
      rop = 2'($urandom_range(0, 3));
      if (kd) begin
        ra = 24'($urandom_range(0, DQ - 1));
        rb = 24'($urandom_range(0, DQ - 1));
      end else begin
        x0 = int'($urandom_range(0, KQ - 1));
        x1 = int'($urandom_range(0, KQ - 1));
        ra = kv(x1, x0);
        x0 = int'($urandom_range(0, KQ - 1));
        x1 = int'($urandom_range(0, KQ - 1));
        rb = kv(x1, x0);
      end
      model(kd, rop, ra, rb, es, ee);
      issue(kd, rop, 1'b0, ra, rb, es, ee, 200 + i);
    end
    drain("random");

    // reset with three ops in flight
    for (int i = 0; i < 3; i++)
      issue(1'b0, 2'b00, 1'b0, kv(100 + i, 200 + i), kv(5, 7), kv(105 + i, 207 + i), 1'b0, 300 + i);
    @(posedge clk);
    #2;
    rst = 1'b0;
    q.delete();
    #1;
    check("async reset out_valid", 32'(bus.out_valid), 32'd0);
    check("async reset sum", 32'(bus.sum), 32'd0);
    check("async reset range_err", 32'(bus.range_err), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    check("no out_valid after reset release", 32'(seen), 32'd0);
    issue(1'b1, 2'b00, 1'b0, 24'd8380000, 24'd417, 24'd0, 1'b0, 400);
    drain("post-reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
